// File: rtl/zrl_bitunpack.sv
// zrl_bitunpack: decoder-side bit unpacker for the ZRL code stream.
// Takes a block header (bit count, 513 = raw 512-bit block) and MSB-first
// packed words, and presents a left-aligned window of up to WIN_W upcoming
// bits to the code parser, which consumes a variable number per cycle.
// Optional feature macro: ZRL_UNPACK_ERR_EN (sticky protocol error flag,
// illegal takes ignored). Without it err_o is 0 and over-long takes are
// clamped to the available bit count.
module zrl_bitunpack #(
    parameter int WORD_W   = 64,
    parameter int WIN_W    = 68,
    parameter int BUF_W    = 144,
    parameter int MAX_BITS = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       size_i,
    input  logic              size_valid_i,
    output logic              size_ready_o,
    input  logic [WORD_W-1:0] word_i,
    input  logic              word_valid_i,
    output logic              word_ready_o,
    output logic [WIN_W-1:0]  win_o,
    output logic [6:0]        win_avail_o,
    input  logic              take_i,
    input  logic [6:0]        take_size_i,
    output logic              raw_o,
    output logic              blk_active_o,
    output logic              eop_o,
    output logic              err_o
);

    localparam int         HDR_RAW = MAX_BITS + 1;
    localparam logic [7:0] WR_LIM  = 8'(BUF_W - WORD_W);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   sbuf_q;
    logic [7:0]         cnt_q;
    logic [9:0]         rem_q;
    logic [3:0]         wleft_q;
    logic               raw_q;
    logic               eop_q;

    logic               hdr_acc, hdr_ok, hdr_raw, word_acc;
    logic               take_req, take_ok, last_take;
    logic [3:0]         hdr_words;
    logic [9:0]         min_cr;
    logic [6:0]         avail, tk;
    logic [7:0]         cnt_tk;
    logic [BUF_W-1:0]   buf_tk, word_pos;
    logic [WIN_W-1:0]   win_mask;
`ifdef ZRL_UNPACK_ERR_EN
    logic               take_bad;
    logic               err_q;
`endif

    // Window sizing, header decode, take resolution and word placement
    always_comb begin
        min_cr    = ({2'b0, cnt_q} < rem_q) ? {2'b0, cnt_q} : rem_q;
        avail     = (min_cr > 10'(WIN_W)) ? 7'(WIN_W) : min_cr[6:0];
        win_mask  = ~({WIN_W{1'b1}} >> avail);
        hdr_raw   = (size_i == 11'(HDR_RAW));
        hdr_ok    = (size_i != 11'd0) && (size_i <= 11'(HDR_RAW));
        hdr_words = 4'((size_i + 11'(WORD_W - 1)) / 11'(WORD_W));
        hdr_acc   = size_valid_i && size_ready_o;
        word_acc  = word_valid_i && word_ready_o;
        take_req  = (state_q == RUN) && take_i;
        take_ok   = (take_size_i <= avail);
`ifdef ZRL_UNPACK_ERR_EN
        // over-long take is dropped and flagged
        tk        = (take_req && take_ok) ? take_size_i : 7'd0;
        take_bad  = take_req && !take_ok;
`else
        // over-long take consumes whatever is visible
        tk        = take_req ? (take_ok ? take_size_i : avail) : 7'd0;
`endif
        last_take = (tk != 7'd0) && ({3'b0, tk} == rem_q);
        // consume first, then the new word lands right behind the survivors
        cnt_tk    = cnt_q - {1'b0, tk};
        buf_tk    = sbuf_q << tk;
        word_pos  = {word_i, {(BUF_W - WORD_W){1'b0}}} >> cnt_tk;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: a good header opens a block, the final take closes it
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hdr_acc && hdr_ok) state_d = RUN;
            RUN:     if (last_take)         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshakes and block-active flag from current registers
    always_comb begin
        size_ready_o = (state_q == IDLE);
        blk_active_o = (state_q == RUN);
        word_ready_o = (state_q == RUN) && (wleft_q != 4'd0) && (cnt_q <= WR_LIM);
    end

    // Shift buffer, counters and block flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbuf_q  <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            wleft_q <= '0;
            raw_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            eop_q <= 1'b0;
            if (state_q == IDLE) begin
                if (hdr_acc && hdr_ok) begin
                    sbuf_q  <= '0;
                    cnt_q   <= '0;
                    rem_q   <= hdr_raw ? 10'(MAX_BITS) : size_i[9:0];
                    wleft_q <= hdr_raw ? 4'(MAX_BITS / WORD_W) : hdr_words;
                    raw_q   <= hdr_raw;
                end
            end else if (last_take) begin
                // pad bits of the last word are thrown away here
                sbuf_q  <= '0;
                cnt_q   <= '0;
                rem_q   <= '0;
                wleft_q <= '0;
                raw_q   <= 1'b0;
                eop_q   <= 1'b1;
            end else begin
                sbuf_q <= buf_tk | (word_acc ? word_pos : '0);
                cnt_q  <= cnt_tk + (word_acc ? 8'(WORD_W) : 8'd0);
                rem_q  <= rem_q - {3'b0, tk};
                if (word_acc) wleft_q <= wleft_q - 4'd1;
            end
        end
    end

`ifdef ZRL_UNPACK_ERR_EN
    // Sticky error: bad header or over-long take; cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              err_q <= 1'b0;
        else if ((hdr_acc && !hdr_ok) || take_bad) err_q <= 1'b1;
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign win_o       = sbuf_q[BUF_W-1 -: WIN_W] & win_mask;
    assign win_avail_o = avail;
    assign raw_o       = raw_q;
    assign eop_o       = eop_q;

endmodule

// File: tb/tb_zrl_bitunpack.sv
// tb_zrl_bitunpack: directed scenarios plus randomized blocks, checked each
// cycle against a bit-queue reference model of the compressed stream.
module tb_zrl_bitunpack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] size_i = '0;
    logic        size_valid_i = 1'b0;
    logic        size_ready_o;
    logic [63:0] word_i = '0;
    logic        word_valid_i = 1'b0;
    logic        word_ready_o;
    logic [67:0] win_o;
    logic [6:0]  win_avail_o;
    logic        take_i = 1'b0;
    logic [6:0]  take_size_i = '0;
    logic        raw_o, blk_active_o, eop_o, err_o;

    always #5 clk = ~clk;

    zrl_bitunpack dut (
        .clk(clk), .rst_n(rst_n),
        .size_i(size_i), .size_valid_i(size_valid_i), .size_ready_o(size_ready_o),
        .word_i(word_i), .word_valid_i(word_valid_i), .word_ready_o(word_ready_o),
        .win_o(win_o), .win_avail_o(win_avail_o),
        .take_i(take_i), .take_size_i(take_size_i),
        .raw_o(raw_o), .blk_active_o(blk_active_o), .eop_o(eop_o), .err_o(err_o)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    // reference model: the block as a queue of not-yet-consumed bits
    bit          m_run, m_raw, m_eop, m_err;
    int          m_rem, m_wleft;
    bit          mq[$];
    logic [63:0] last_word;

    function automatic int m_avail();
        int a;
        if (!m_run) return 0;
        a = mq.size();
        if (m_rem < a) a = m_rem;
        if (a > 68) a = 68;
        return a;
    endfunction

    function automatic logic [67:0] m_win();
        logic [67:0] w = '0;
        int a = m_avail();
        for (int i = 0; i < a; i++) w[67-i] = mq[i];
        return w;
    endfunction

    function automatic bit m_wready();
        return m_run && (m_wleft > 0) && (mq.size() <= 80);
    endfunction

    task automatic model_reset();
        m_run = 0; m_raw = 0; m_eop = 0; m_err = 0;
        m_rem = 0; m_wleft = 0; mq.delete();
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".srdy"},  size_ready_o, !m_run);
        chk({ph, ".wrdy"},  word_ready_o, m_wready());
        chk({ph, ".win"},   win_o, m_win());
        chk({ph, ".avail"}, win_avail_o, m_avail());
        chk({ph, ".raw"},   raw_o, m_raw);
        chk({ph, ".act"},   blk_active_o, m_run);
        chk({ph, ".eop"},   eop_o, m_eop);
        chk({ph, ".err"},   err_o, m_err);
    endtask

    // one clock: drive at negedge, advance model, check at next negedge
    task automatic step(input string ph, input bit sv, input int sz,
                        input bit wv, input bit tv, input int ts);
        bit pushed = 0;
        int a, tk;
        size_valid_i = sv; size_i = sz[10:0];
        word_valid_i = wv; take_i = tv; take_size_i = ts[6:0];
        m_eop = 0;
        if (!m_run) begin
            if (sv) begin
                if (sz >= 1 && sz <= 513) begin
                    m_run = 1; m_raw = (sz == 513);
                    m_rem = (sz == 513) ? 512 : sz;
                    m_wleft = (m_rem + 63) / 64;
                    mq.delete();
                end else begin
`ifdef ZRL_UNPACK_ERR_EN
                    m_err = 1;
`endif
                end
            end
        end else begin
            a = m_avail();
            tk = 0;
            if (tv) begin
                if (ts <= a) tk = ts;
                else begin
`ifdef ZRL_UNPACK_ERR_EN
                    m_err = 1;
`else
                    tk = a;
`endif
                end
            end
            if (wv && m_wready()) pushed = 1;
            repeat (tk) void'(mq.pop_front());
            m_rem -= tk;
            if (tk > 0 && m_rem == 0) begin
                m_run = 0; m_raw = 0; m_eop = 1; mq.delete(); m_wleft = 0;
                pushed = 0;
            end else if (pushed) begin
                for (int i = 63; i >= 0; i--) mq.push_back(word_i[i]);
                m_wleft--;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (pushed) begin
            last_word = word_i;
            word_i = {$urandom, $urandom};
        end
        check_all(ph);
    endtask

    initial begin
        int sz, r, a, ts, guard;
        model_reset();
        word_i = {$urandom, $urandom};
        @(negedge clk);
        check_all("reset");
        chk("reset.srdy1", size_ready_o, 1'b1);
        rst_n = 1'b1;

        // 1: header 130, three words, takes of 68 then 62
        step("t1.hdr", 1, 130, 0, 0, 0);
        step("t1.w0", 0, 0, 1, 0, 0);
        step("t1.w1", 0, 0, 1, 0, 0);
        chk("t1.avail68", win_avail_o, 7'd68);
        step("t1.tk68", 0, 0, 1, 1, 68);
        step("t1.w2", 0, 0, 1, 0, 0);
        chk("t1.avail62", win_avail_o, 7'd62);
        step("t1.tk62", 0, 0, 0, 1, 62);
        chk("t1.eop", eop_o, 1'b1);
        chk("t1.avail0", win_avail_o, 7'd0);
        step("t1.idle", 0, 0, 0, 0, 0);
        chk("t1.srdy", size_ready_o, 1'b1);

        // 2: raw block, window equals each word
        step("t2.hdr", 1, 513, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step("t2.w", 0, 0, 1, 0, 0);
            chk("t2.raw", raw_o, 1'b1);
            chk("t2.win", win_o, {last_word, 4'h0});
            step("t2.tk", 0, 0, 0, 1, 64);
        end
        chk("t2.eop", eop_o, 1'b1);

        // 3: header 512, backpressure after two words, take 48 reopens
        step("t3.hdr", 1, 512, 0, 0, 0);
        step("t3.w0", 0, 0, 1, 0, 0);
        step("t3.w1", 0, 0, 1, 0, 0);
        step("t3.hold", 0, 0, 1, 0, 0);
        chk("t3.wrdy0", word_ready_o, 1'b0);
        step("t3.tk48", 0, 0, 1, 1, 48);
        chk("t3.wrdy1", word_ready_o, 1'b1);

        // 4: take 20 and word in the same cycle at 80 buffered bits
        step("t4.tkw", 0, 0, 1, 1, 20);
        chk("t4.cnt", mq.size(), 124);
        guard = 0;
        while (m_run && guard < 300) begin
            a = m_avail();
            step("t4.drain", 0, 0, 1, 1, $urandom_range(0, a));
            guard++;
        end
        chk("t4.done", blk_active_o, 1'b0);

        // 5: over-long take with 10 bits visible
        step("t5.hdr", 1, 10, 0, 0, 0);
        step("t5.w", 0, 0, 1, 0, 0);
        chk("t5.avail10", win_avail_o, 7'd10);
        step("t5.tk11", 0, 0, 0, 1, 11);
`ifdef ZRL_UNPACK_ERR_EN
        chk("t5.err", err_o, 1'b1);
        chk("t5.kept", win_avail_o, 7'd10);
`else
        chk("t5.clamp", eop_o, 1'b1);
`endif
        if (m_run) step("t5.fin", 0, 0, 0, 1, m_avail());

        // 6: reset mid-block, then a clean 64-bit block
        step("t6.hdr", 1, 150, 0, 0, 0);
        step("t6.w0", 0, 0, 1, 0, 0);
        step("t6.tk", 0, 0, 1, 1, 30);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("t6.rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("t6.hdr64", 1, 64, 0, 0, 0);
        step("t6.w", 0, 0, 1, 0, 0);
        step("t6.tk64", 0, 0, 0, 1, 64);
        chk("t6.eop", eop_o, 1'b1);

        // randomized blocks
        for (int b = 0; b < 30; b++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      sz = 513;
            else if (r == 1) sz = ($urandom_range(0, 1) == 0) ? 0 : 514 + $urandom_range(0, 500);
            else             sz = $urandom_range(1, 512);
            step("rnd.hdr", 1, sz, 0, 0, 0);
            guard = 0;
            while (m_run && guard < 400) begin
                a = m_avail();
                r = $urandom_range(0, 9);
                ts = (r == 0 && a < 68) ? $urandom_range(a + 1, 68) : $urandom_range(0, a);
                step("rnd", $urandom_range(0, 1), $urandom_range(0, 600),
                     $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, ts);
                guard++;
            end
            chk("rnd.bound", m_run, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
